// File: rtl/dlx_data_mem_responder.sv
// Data-memory responder for the DLX pipeline: word RAM plus a 16-byte MMIO window
// (GPIO, cycle counter, error status), with registered one-cycle read data.
module dlx_data_mem_responder #(
  parameter int                         DATA_WIDTH      = 32,
  parameter int                         DATA_ADDR_WIDTH = 32,
  parameter int                         MEM_DEPTH_LOG2  = 10,
  parameter logic [DATA_ADDR_WIDTH-1:0] RAM_BASE        = 32'h0000_0000,
  parameter logic [DATA_ADDR_WIDTH-1:0] MMIO_BASE       = 32'hFFFF_0000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       data_rd_en,
  input  logic                       data_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]      data_write,
  output logic [DATA_WIDTH-1:0]      data_read,
  input  logic [31:0]                gpio_in,
  output logic [31:0]                gpio_out,
  output logic                       err_flag,
  output logic [7:0]                 err_count
);

  localparam int AW1 = DATA_ADDR_WIDTH + 1;
  // Range bounds carry one extra bit so a region ending at the top of the address space cannot wrap.
  localparam logic [DATA_ADDR_WIDTH:0] RAM_LO  = {1'b0, RAM_BASE};
  localparam logic [DATA_ADDR_WIDTH:0] RAM_HI  = RAM_LO + (AW1'(1) << (MEM_DEPTH_LOG2 + 2));
  localparam logic [DATA_ADDR_WIDTH:0] MMIO_LO = {1'b0, MMIO_BASE};
  localparam logic [DATA_ADDR_WIDTH:0] MMIO_HI = MMIO_LO + AW1'(16);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_UNMAP = 2'd2;
  localparam logic [1:0] ERR_PROTO = 2'd3;

  localparam logic [1:0] REG_GPIO_OUT = 2'd0;
  localparam logic [1:0] REG_GPIO_IN  = 2'd1;
  localparam logic [1:0] REG_CYCLE    = 2'd2;
  localparam logic [1:0] REG_ERR      = 2'd3;

  logic [DATA_WIDTH-1:0] mem [2**MEM_DEPTH_LOG2];

  logic [31:0] cycle_cnt;
  logic [1:0]  last_code;

  logic [DATA_ADDR_WIDTH:0]   addr_ext_p0;
  logic [DATA_ADDR_WIDTH-1:0] ram_off_p0;
  logic [DATA_ADDR_WIDTH-1:0] mmio_off_p0;
  logic [MEM_DEPTH_LOG2-1:0]  ram_idx_p0;
  logic [1:0]                 reg_sel_p0;
  logic [1:0]                 err_code_p0;
  logic                       ram_hit_p0;
  logic                       mmio_hit_p0;
  logic                       err_p0;
  logic                       rd_ok_p0;
  logic                       wr_ok_p0;
  logic [DATA_WIDTH-1:0]      rd_mux_p0;
  logic                       unused_p0;

  function automatic logic [7:0] sat_inc8(input logic [7:0] c);
    return (c == 8'hFF) ? c : c + 8'd1;
  endfunction

  // Stage p0: decode of the request presented this cycle
  assign addr_ext_p0 = {1'b0, data_addr};
  assign ram_hit_p0  = (addr_ext_p0 >= RAM_LO) && (addr_ext_p0 < RAM_HI);
  assign mmio_hit_p0 = (addr_ext_p0 >= MMIO_LO) && (addr_ext_p0 < MMIO_HI);
  assign ram_off_p0  = data_addr - RAM_BASE;
  assign mmio_off_p0 = data_addr - MMIO_BASE;
  assign ram_idx_p0  = ram_off_p0[MEM_DEPTH_LOG2+1:2];
  assign reg_sel_p0  = mmio_off_p0[3:2];
  assign unused_p0   = ^{ram_off_p0[DATA_ADDR_WIDTH-1:MEM_DEPTH_LOG2+2], ram_off_p0[1:0],
                         mmio_off_p0[DATA_ADDR_WIDTH-1:4], mmio_off_p0[1:0]};

  always_comb begin
    err_code_p0 = ERR_NONE;
    if (data_rd_en && data_wr_en)          err_code_p0 = ERR_PROTO;
    else if (data_addr[1:0] != 2'b00)      err_code_p0 = ERR_ALIGN;
    else if (!ram_hit_p0 && !mmio_hit_p0)  err_code_p0 = ERR_UNMAP;
  end

  assign err_p0   = (data_rd_en || data_wr_en) && (err_code_p0 != ERR_NONE);
  assign rd_ok_p0 = data_rd_en && !err_p0;
  assign wr_ok_p0 = data_wr_en && !err_p0;

  always_comb begin
    rd_mux_p0 = '0;
    if (ram_hit_p0) begin
      rd_mux_p0 = mem[ram_idx_p0];
    end else if (mmio_hit_p0) begin
      case (reg_sel_p0)
        REG_GPIO_OUT: rd_mux_p0 = DATA_WIDTH'(gpio_out);
        REG_GPIO_IN:  rd_mux_p0 = DATA_WIDTH'(gpio_in);
        REG_CYCLE:    rd_mux_p0 = DATA_WIDTH'(cycle_cnt);
        default:      rd_mux_p0 = DATA_WIDTH'({16'h0, err_count, 6'h0, last_code});
      endcase
    end
  end

  // Stage p1: RAM contents survive reset, so no reset term here
  always_ff @(posedge clk) begin
    if (rst_n && wr_ok_p0 && ram_hit_p0) begin
      mem[ram_idx_p0] <= data_write;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_read <= '0;
      gpio_out  <= '0;
      err_flag  <= 1'b0;
      err_count <= '0;
      last_code <= ERR_NONE;
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (err_p0) begin
        err_flag  <= 1'b1;
        last_code <= err_code_p0;
        err_count <= sat_inc8(err_count);
      end
      if (data_rd_en) begin
        data_read <= rd_ok_p0 ? rd_mux_p0 : '0;
      end
      // An ERR_STATUS clear is itself a valid write, so it never coincides with an error above.
      if (wr_ok_p0 && mmio_hit_p0) begin
        case (reg_sel_p0)
          REG_GPIO_OUT: gpio_out  <= 32'(data_write);
          REG_CYCLE:    cycle_cnt <= '0;
          REG_ERR: begin
            err_flag  <= 1'b0;
            err_count <= '0;
            last_code <= ERR_NONE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dlx_data_mem_responder.sv
// Directed bench for dlx_data_mem_responder: vector table plus hand sequences
// for cycle counter, error saturation and mid-sequence reset.
module tb_dlx_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_rd_en;
  logic        data_wr_en;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic [31:0] gpio_in;
  logic [31:0] gpio_out;
  logic        err_flag;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;

  dlx_data_mem_responder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_rd_en (data_rd_en),
    .data_wr_en (data_wr_en),
    .data_addr  (data_addr),
    .data_write (data_write),
    .data_read  (data_read),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out),
    .err_flag   (err_flag),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] gin;
    logic [31:0] exp_rd;
    logic [31:0] exp_gpio;
    logic        exp_flag;
    logic [7:0]  exp_cnt;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    data_rd_en = rd;
    data_wr_en = wr;
    data_addr  = a;
    data_write = d;
  endtask

  logic [31:0] cyc_a, cyc_b;

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'd0};
    vecs[1]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 32'h0000_0000, 32'h0000_0000, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0, 32'h1234_5678, 32'h0000_0000, 1'b0, 8'd0};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0, 32'h1234_5678, 32'h0000_0000, 1'b0, 8'd0};
    vecs[4]  = '{1'b0, 1'b1, 32'hFFFF_0000, 32'hA5A5_0001, 32'h0, 32'h1234_5678, 32'hA5A5_0001, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 32'hFFFF_0004, 32'h0,         32'hFF, 32'h0000_00FF, 32'hA5A5_0001, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 1'b0, 32'hFFFF_0000, 32'h0,         32'h0, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 8'd0};
    vecs[7]  = '{1'b0, 1'b1, 32'hFFFF_0004, 32'h0000_DEAD, 32'h0, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 8'd0};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         32'h0, 32'hCAFE_F00D, 32'hA5A5_0001, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_0002, 32'h0,         32'h0, 32'h0000_0000, 32'hA5A5_0001, 1'b1, 8'd1};
    vecs[11] = '{1'b0, 1'b1, 32'h0001_0000, 32'h0000_0BAD, 32'h0, 32'h0000_0000, 32'hA5A5_0001, 1'b1, 8'd2};
    vecs[12] = '{1'b1, 1'b0, 32'hFFFF_000C, 32'h0,         32'h0, 32'h0000_0202, 32'hA5A5_0001, 1'b1, 8'd2};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         32'h0, 32'h1111_1111, 32'hA5A5_0001, 1'b1, 8'd2};
    vecs[14] = '{1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0, 32'h0000_0000, 32'hA5A5_0001, 1'b1, 8'd3};
    vecs[15] = '{1'b1, 1'b0, 32'hFFFF_000C, 32'h0,         32'h0, 32'h0000_0302, 32'hA5A5_0001, 1'b1, 8'd3};
    vecs[16] = '{1'b1, 1'b0, 32'hFFFF_0001, 32'h0,         32'h0, 32'h0000_0000, 32'hA5A5_0001, 1'b1, 8'd4};
    vecs[17] = '{1'b1, 1'b0, 32'hFFFF_000C, 32'h0,         32'h0, 32'h0000_0401, 32'hA5A5_0001, 1'b1, 8'd4};
    vecs[18] = '{1'b0, 1'b1, 32'hFFFF_000C, 32'h0,         32'h0, 32'h0000_0401, 32'hA5A5_0001, 1'b0, 8'd0};
    vecs[19] = '{1'b1, 1'b0, 32'hFFFF_000C, 32'h0,         32'h0, 32'h0000_0000, 32'hA5A5_0001, 1'b0, 8'd0};
    vecs[20] = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0, 32'h1234_5678, 32'hA5A5_0001, 1'b0, 8'd0};

    rst_n   = 1'b0;
    gpio_in = 32'h0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    step();
    check("rst.data_read", data_read, 32'h0);
    check("rst.gpio_out", gpio_out, 32'h0);
    check("rst.err_flag", {31'h0, err_flag}, 32'h0);
    check("rst.err_count", {24'h0, err_count}, 32'h0);

    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
    step();
    check("rst.cycle", data_read, 32'h0);

    for (int i = 0; i < NV; i++) begin
      gpio_in = vecs[i].gin;
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      step();
      check($sformatf("vec%0d.data_read", i), data_read, vecs[i].exp_rd);
      check($sformatf("vec%0d.gpio_out", i), gpio_out, vecs[i].exp_gpio);
      check($sformatf("vec%0d.err_flag", i), {31'h0, err_flag}, {31'h0, vecs[i].exp_flag});
      check($sformatf("vec%0d.err_count", i), {24'h0, err_count}, {24'h0, vecs[i].exp_cnt});
    end
    gpio_in = 32'h0;

    // Cycle counter: back-to-back reads, then clear and read two cycles later
    drive(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
    step();
    cyc_a = data_read;
    step();
    cyc_b = data_read;
    check("cycle.delta", cyc_b - cyc_a, 32'd1);
    drive(1'b0, 1'b1, 32'hFFFF_0008, 32'h0000_1234);
    step();
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    drive(1'b1, 1'b0, 32'hFFFF_0008, 32'h0);
    step();
    check("cycle.after_clear", data_read, 32'd1);
    check("cycle.no_err", {31'h0, err_flag}, 32'h0);

    // Protocol errors: count saturates, no RAM write, code 3
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 1'b1, 32'h0000_0010, 32'hFFFF_FFFF);
      step();
      check($sformatf("sat%0d.err_count", i), {24'h0, err_count}, (i + 1 > 255) ? 32'd255 : 32'(i + 1));
    end
    check("sat.data_read", data_read, 32'h0);
    check("sat.err_flag", {31'h0, err_flag}, 32'h1);
    drive(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);
    step();
    check("sat.status", data_read, 32'h0000_FF03);
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    step();
    check("sat.ram_kept", data_read, 32'h1234_5678);
    drive(1'b0, 1'b1, 32'hFFFF_000C, 32'h0);
    step();
    drive(1'b1, 1'b0, 32'hFFFF_000C, 32'h0);
    step();
    check("sat.cleared_status", data_read, 32'h0);
    check("sat.cleared_flag", {31'h0, err_flag}, 32'h0);

    // Reset between a read and later requests; a write presented during reset is ignored
    drive(1'b1, 1'b0, 32'h0000_1000, 32'h0);
    step();
    check("mid.pre_err", {24'h0, err_count}, 32'd1);
    drive(1'b1, 1'b0, 32'h0000_0FFC, 32'h0);
    step();
    check("mid.pre_read", data_read, 32'hCAFE_F00D);
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 32'h0000_0010, 32'h0);
    step();
    check("mid.data_read", data_read, 32'h0);
    check("mid.gpio_out", gpio_out, 32'h0);
    check("mid.err_flag", {31'h0, err_flag}, 32'h0);
    check("mid.err_count", {24'h0, err_count}, 32'h0);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    step();
    check("mid.ram_kept", data_read, 32'h1234_5678);
    drive(1'b1, 1'b0, 32'h0000_0FFC, 32'h0);
    step();
    check("mid.ram_kept2", data_read, 32'hCAFE_F00D);
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("mid.hold", data_read, 32'hCAFE_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dlx_data_mem_responder.md
# dlx_data_mem_responder

Responder side of the processor data-memory port: accepts single-cycle read/write requests from the pipeline's memory stage and returns read data one cycle later. That return timing matches the write-back stage's sampling of `data_read`. Holds a word-addressed RAM region plus a small MMIO register window: GPIO, a cycle counter and error status. Detects and logs protocol and address errors. Sits between the processor top and the board-level I/O.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data word width.
- `DATA_ADDR_WIDTH`, 32, byte address width.
- `MEM_DEPTH_LOG2`, 10, log2 of RAM words (default 1024 words = 4 KiB).
- `RAM_BASE`, 32'h0000_0000, byte base of the RAM region.
- `MMIO_BASE`, 32'hFFFF_0000, byte base of the 16-byte MMIO window.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `data_rd_en` in 1: read request, valid this cycle.
- `data_wr_en` in 1: write request, valid this cycle.
- `data_addr` in DATA_ADDR_WIDTH: byte address of the request.
- `data_write` in DATA_WIDTH: write data.
- `data_read` out DATA_WIDTH: registered read data.
- `gpio_in` in 32: external input, readable through MMIO.
- `gpio_out` out 32: GPIO output register.
- `err_flag` out 1: sticky error indication.
- `err_count` out 8: saturating error counter.

## Operation
Requests are single-cycle with no handshake and no stall. Every request is accepted in the cycle it is presented.

Address decode, evaluated per request:
- Misaligned: `data_addr[1:0] != 0`. Error code 1.
- RAM hit: `RAM_BASE <= addr < RAM_BASE + 4*2^MEM_DEPTH_LOG2`. Word index = `(addr - RAM_BASE) >> 2`.
- MMIO hit: `MMIO_BASE <= addr < MMIO_BASE + 16`.
- Anything else is unmapped. Error code 2.
- `data_rd_en && data_wr_en` in the same cycle is a protocol error. Error code 3. It takes priority over codes 1 and 2.
- On any error, the write is suppressed and a read returns 0.

MMIO map (byte offsets):
- 0x0 GPIO_OUT: read/write.
- 0x4 GPIO_IN: read-only. Reads return `gpio_in` sampled at the request edge. Writes are ignored and are not an error.
- 0x8 CYCLE: 32-bit free-running counter, +1 every cycle, wraps at 2^32. A write of any value clears it to 0 on that edge; it then counts from 0 the next cycle.
- 0xC ERR_STATUS: reads return {16'h0, err_count, 6'h0, last_code[1:0]}. A write clears `err_flag`, `err_count` and `last_code`.

Error logging:
- On an error, set `err_flag` and store `last_code`.
- Increment `err_count`, saturating at 255.
- If an error occurs in the same cycle as an ERR_STATUS clear, the clear wins. This cannot arise, because a clear is itself a valid write.

RAM:
- Writes update `mem[index]` at the request edge.
- Reads load `data_read` from `mem[index]` at the request edge.
- Reset does not clear RAM contents.

## Timing
- Read latency is exactly 1 cycle. A request with `data_rd_en` at edge N puts the data on `data_read` from N to N+1.
- `data_read` holds its last value in cycles without a read.
- A write at edge N is visible to a read requested at edge N+1, so the data appears at N+1.
- Writes have no output response.

Reset (`rst_n` = 0 at an edge):
- `data_read` = 0, `gpio_out` = 0, `err_flag` = 0, `err_count` = 0, `last_code` = 0, CYCLE = 0.
- A request presented during reset is ignored: no write, no error logged.
- Reset in the middle of a sequence discards any pending read result. `data_read` becomes 0.

CYCLE read at edge N returns the counter value held before edge N. Two reads one cycle apart therefore differ by 1.

## Test plan
- Reset, then write 32'h1234_5678 to 0x0000_0010, then read it the next cycle -> `data_read` = 32'h1234_5678 one cycle after the read; reads with no intervening write keep the value.
- Write 32'hA5A5_0001 to 0xFFFF_0000 -> `gpio_out` = 32'hA5A5_0001 the cycle after; a read of 0xFFFF_0004 with `gpio_in` = 32'h0000_00FF -> `data_read` = 32'h0000_00FF.
- Read 0xFFFF_0008 at two consecutive edges -> values differ by 1; write 0 to CYCLE, then read two cycles later -> 1.
- Read 0x0000_0002 (misaligned), then write 0x0001_0000 (unmapped) -> `data_read` = 0 and `err_flag` = 1. `err_count` = 2, and ERR_STATUS reads 32'h0000_0202. RAM is unchanged.
- Assert `data_rd_en` and `data_wr_en` together on a RAM address 256 times -> `err_count` saturates at 255, with code 3 and no RAM write. Then write ERR_STATUS -> flag, count and code read 0.
- Pulse `rst_n` low for one edge between a RAM read request and its return -> `data_read` = 0, and previously written RAM data is still readable afterwards.
